pdm_cic_decimator: RTL



---
 rtl/pdm_pkg.sv | 23 ++
 rtl/pdm_clk_gen.sv | 51 +++++
 rtl/pdm_cic_decimator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared defaults and helpers for the PDM microphone front end.
//   CLK_DIV_DEF : clk cycles per pdm_clk period
//   CIC_N_DEF   : CIC order
//   CIC_R_DEF   : CIC decimation ratio (power of two)
//   PCM_W_DEF   : PCM output word width
//   acc_w()     : CIC accumulator width needed for order n, ratio r
//   pcm_t       : signed PCM word at the default width
package pdm_pkg;

  localparam int CLK_DIV_DEF = 12;
  localparam int CIC_N_DEF   = 3;
  localparam int CIC_R_DEF   = 64;
  localparam int PCM_W_DEF   = 16;

  // Integer growth is n*log2(r) bits on top of the +/-1 input.
  // The two extra bits hold the sign and the +r^n end of the range.
  function automatic int acc_w(input int n, input int r);
    return n * $clog2(r) + 2;
  endfunction

  typedef logic signed [PCM_W_DEF-1:0] pcm_t;

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM clock divider, data synchronizer and sample strobe.
// The raw-capture path uses this block as well.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous, active-high reset
//   pdm_clk    out registered mic clock with 50% duty, CLK_DIV clk per period
//   pdm_dat    in  mic data, asynchronous to clk
//   pdm_bit    out pdm_dat after a 2-flop synchronizer
//   sample_stb out single-cycle strobe at the last divider count
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pdm_clk,
  input  logic pdm_dat,
  output logic pdm_bit,
  output logic sample_stb
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic [1:0]       sync_q, sync_d;

  always_comb begin
    cnt_d      = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    pdm_clk_d  = (cnt_q < CNT_W'(CLK_DIV / 2));
    sync_d     = {sync_q[0], pdm_dat};
    sample_stb = (cnt_q == CNT_W'(CLK_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pdm_clk_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
      sync_q    <= sync_d;
    end
  end

  assign pdm_clk = pdm_clk_q;
  assign pdm_bit = sync_q[1];

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM decimator: drives the mic clock, runs a CIC_N-order CIC with
// ratio CIC_R over the 1-bit stream and hands out signed PCM_W-bit words
// through a valid/ready interface with overrun indication.
// Build option: PDM_CIC_DCBLOCK_EN adds a first-order DC blocker after
// saturation (one extra clk of latency); undefined gives raw CIC output.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous, active-high reset
//   pdm_clk    out mic clock
//   pdm_dat    in  mic data, asynchronous to clk
//   pcm_data   out signed PCM sample
//   pcm_valid  out pcm_data holds an unconsumed sample
//   pcm_ready  in  consumer accepts when pcm_valid && pcm_ready
//   overrun    out 1-cycle pulse when a sample replaced an unconsumed one
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CIC_N   = CIC_N_DEF,
  parameter int CIC_R   = CIC_R_DEF,
  parameter int PCM_W   = PCM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pdm_clk,
  input  logic             pdm_dat,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun
);

  localparam int ACC_W  = acc_w(CIC_N, CIC_R);
  localparam int DEC_W  = $clog2(CIC_R);
  localparam int WARM_W = $clog2(CIC_N + 1);
  localparam int SHIFT  = ACC_W - 1 - PCM_W;

  typedef logic signed [ACC_W-1:0] acc_t;
  localparam acc_t SAT_MAX = acc_t'({2'b00, {(ACC_W-2){1'b1}}});
  localparam acc_t SAT_MIN = acc_t'({2'b11, {(ACC_W-2){1'b0}}});

  logic pdm_bit, sample_stb;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .pdm_clk    (pdm_clk),
    .pdm_dat    (pdm_dat),
    .pdm_bit    (pdm_bit),
    .sample_stb (sample_stb)
  );

  acc_t             integ_q [CIC_N];
  acc_t             integ_d [CIC_N];
  acc_t             dly_q   [CIC_N];
  acc_t             dly_d   [CIC_N];
  acc_t             comb_q, comb_d;
  logic             comb_vld_q, comb_vld_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic             decim, keep;
  acc_t             x, carry, sat_val;
  logic [PCM_W-1:0] cic_pcm;

  always_comb begin
    x         = pdm_bit ? acc_t'(1) : acc_t'(-1);
    decim     = sample_stb && (dec_cnt_q == DEC_W'(CIC_R - 1));
    dec_cnt_d = sample_stb ? dec_cnt_q + 1'b1 : dec_cnt_q;
    integ_d   = integ_q;
    dly_d     = dly_q;
    comb_d    = comb_q;
    // Integrator chain; carry ends as the updated last-stage value, which
    // is what the comb section sees on a decimation strobe.
    carry = x;
    for (int i = 0; i < CIC_N; i++) begin
      carry = integ_q[i] + carry;
      if (sample_stb) integ_d[i] = carry;
    end
    for (int i = 0; i < CIC_N; i++) begin
      if (decim) dly_d[i] = carry;
      carry = carry - dly_q[i];
    end
    if (decim) comb_d = carry;
    comb_vld_d = decim;

    // The first CIC_N results still carry the start-up transient.
    keep   = comb_vld_q && (warm_q == WARM_W'(CIC_N));
    warm_d = (comb_vld_q && !keep) ? warm_q + 1'b1 : warm_q;

    if (comb_q > SAT_MAX)      sat_val = SAT_MAX;
    else if (comb_q < SAT_MIN) sat_val = SAT_MIN;
    else                       sat_val = comb_q;
    cic_pcm = PCM_W'(sat_val >>> SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CIC_N; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      comb_q     <= '0;
      comb_vld_q <= 1'b0;
      dec_cnt_q  <= '0;
      warm_q     <= '0;
    end else begin
      integ_q    <= integ_d;
      dly_q      <= dly_d;
      comb_q     <= comb_d;
      comb_vld_q <= comb_vld_d;
      dec_cnt_q  <= dec_cnt_d;
      warm_q     <= warm_d;
    end
  end

  logic             new_sample;
  logic [PCM_W-1:0] new_val;

`ifdef PDM_CIC_DCBLOCK_EN
  localparam int DC_W = PCM_W + 8;
  typedef logic signed [DC_W-1:0] dc_t;
  localparam dc_t DC_MAX = dc_t'((2 ** (PCM_W - 1)) - 1);
  localparam dc_t DC_MIN = dc_t'(-(2 ** (PCM_W - 1)));

  logic [PCM_W-1:0] dc_x_q, dc_x_d;
  dc_t              dc_y_q, dc_y_d, dc_sat;
  logic             dc_vld_q, dc_vld_d;

  always_comb begin
    dc_x_d   = dc_x_q;
    dc_y_d   = dc_y_q;
    dc_vld_d = keep;
    if (keep) begin
      dc_x_d = cic_pcm;
      dc_y_d = dc_t'({{8{cic_pcm[PCM_W-1]}}, cic_pcm})
             - dc_t'({{8{dc_x_q[PCM_W-1]}}, dc_x_q})
             + dc_y_q - (dc_y_q >>> 8);
    end
    if (dc_y_q > DC_MAX)      dc_sat = DC_MAX;
    else if (dc_y_q < DC_MIN) dc_sat = DC_MIN;
    else                      dc_sat = dc_y_q;
    new_sample = dc_vld_q;
    new_val    = PCM_W'(dc_sat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_x_q   <= '0;
      dc_y_q   <= '0;
      dc_vld_q <= 1'b0;
    end else begin
      dc_x_q   <= dc_x_d;
      dc_y_q   <= dc_y_d;
      dc_vld_q <= dc_vld_d;
    end
  end
`else
  always_comb begin
    new_sample = keep;
    new_val    = cic_pcm;
  end
`endif

  logic [PCM_W-1:0] pcm_data_q, pcm_data_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  always_comb begin
    accept      = pcm_valid_q && pcm_ready;
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q;
    overrun_d   = 1'b0;
    // A fresh sample always wins; an accept in the same cycle just means
    // nothing was lost.
    if (new_sample) begin
      pcm_data_d  = new_val;
      pcm_valid_d = 1'b1;
      overrun_d   = pcm_valid_q && !pcm_ready;
    end else if (accept) begin
      pcm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule
